// File: rtl/authentication.sv
// Morse game login front-end: 4-digit ID lookup in a constant ROM, then 6-digit password check.
// Optional guest login (ID 0000) is enabled by defining AUTH_GUEST_EN.
module authentication (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] UserDigit,
    input  logic       UserLoad,
    input  logic       logout_from_gamectrl,
    output logic       LoggedIn,
    output logic [2:0] PlayerID_from_pswd,
    output logic       isGuest_from_PSWD,
    output logic       LoggedInLED
);

    localparam int unsigned DIGIT_W  = 4;
    localparam int unsigned ID_W     = 4 * DIGIT_W;
    localparam int unsigned PW_W     = 6 * DIGIT_W;
    localparam int unsigned IDX_W    = 3;
    localparam int unsigned CNT_W    = 3;
    localparam int unsigned ID_LAST  = 3;
    localparam int unsigned PW_LAST  = 5;
    localparam int unsigned IDX_LAST = 7;

    typedef enum logic [1:0] {
        ID_ENTRY,
        SEARCH,
        PSWD_ENTRY,
        LOGGED_IN
    } state_e;

    // Constant credential ROM; only entries 1 and 2 are populated, the rest never match.
    function automatic logic rom_id_hit(input logic [IDX_W-1:0] idx, input logic [ID_W-1:0] id);
        case (idx)
            IDX_W'(1): rom_id_hit = (id == ID_W'(16'h5973));
            IDX_W'(2): rom_id_hit = (id == ID_W'(16'h6197));
            default:   rom_id_hit = 1'b0;
        endcase
    endfunction

    function automatic logic [PW_W-1:0] rom_pw(input logic [IDX_W-1:0] idx);
        case (idx)
            IDX_W'(1): rom_pw = PW_W'(24'hA04A54);
            IDX_W'(2): rom_pw = PW_W'(24'h8957D1);
            default:   rom_pw = '0;
        endcase
    endfunction

    state_e              state_q, state_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                mis_q, mis_d;
    logic                load_prev_q;
    logic                logged_q, logged_d;
    logic [IDX_W-1:0]    pid_q, pid_d;
    logic                guest_q, guest_d;
    logic                strobe_c;
    logic [PW_W-1:0]     pw_c;
    logic [DIGIT_W-1:0]  pw_digit_c;
    logic                digit_eq_c;

    assign strobe_c = UserLoad & ~load_prev_q;
    assign pw_c     = rom_pw(idx_q);

    // Expected password digit for the current position, first-entered digit in the top nibble.
    always_comb begin
        case (cnt_q)
            CNT_W'(0): pw_digit_c = pw_c[23:20];
            CNT_W'(1): pw_digit_c = pw_c[19:16];
            CNT_W'(2): pw_digit_c = pw_c[15:12];
            CNT_W'(3): pw_digit_c = pw_c[11:8];
            CNT_W'(4): pw_digit_c = pw_c[7:4];
            default:   pw_digit_c = pw_c[3:0];
        endcase
    end

    assign digit_eq_c = (UserDigit == pw_digit_c);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ID_ENTRY;
            id_q        <= '0;
            cnt_q       <= '0;
            idx_q       <= '0;
            mis_q       <= 1'b0;
            load_prev_q <= 1'b0;
            logged_q    <= 1'b0;
            pid_q       <= '0;
            guest_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            id_q        <= id_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            mis_q       <= mis_d;
            load_prev_q <= UserLoad;
            logged_q    <= logged_d;
            pid_q       <= pid_d;
            guest_q     <= guest_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        id_d     = id_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        mis_d    = mis_q;
        // Outputs follow the state one edge later; guest sessions are marked by index 0.
        logged_d = (state_q == LOGGED_IN);
        pid_d    = (state_q == LOGGED_IN) ? idx_q : '0;
`ifdef AUTH_GUEST_EN
        guest_d  = (state_q == LOGGED_IN) && (idx_q == '0);
`else
        guest_d  = 1'b0;
`endif

        case (state_q)
            ID_ENTRY: begin
                if (strobe_c) begin
                    id_d = {id_q[ID_W-DIGIT_W-1:0], UserDigit};
                    if (cnt_q == CNT_W'(ID_LAST)) begin
                        cnt_d   = '0;
                        idx_d   = IDX_W'(1);
                        state_d = SEARCH;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            SEARCH: begin
`ifdef AUTH_GUEST_EN
                if (id_q == '0) begin
                    idx_d   = '0;
                    state_d = LOGGED_IN;
                end else
`endif
                if (rom_id_hit(idx_q, id_q)) begin
                    cnt_d   = '0;
                    mis_d   = 1'b0;
                    state_d = PSWD_ENTRY;
                end else if (idx_q == IDX_W'(IDX_LAST)) begin
                    id_d    = '0;
                    idx_d   = '0;
                    state_d = ID_ENTRY;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end

            PSWD_ENTRY: begin
                if (strobe_c) begin
                    if (cnt_q == CNT_W'(PW_LAST)) begin
                        cnt_d = '0;
                        mis_d = 1'b0;
                        id_d  = '0;
                        if (!mis_q && digit_eq_c) begin
                            state_d = LOGGED_IN;
                        end else begin
                            idx_d   = '0;
                            state_d = ID_ENTRY;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                        mis_d = mis_q | ~digit_eq_c;
                    end
                end
            end

            LOGGED_IN: begin
                if (logout_from_gamectrl) begin
                    idx_d   = '0;
                    state_d = ID_ENTRY;
                end
            end

            default: state_d = ID_ENTRY;
        endcase
    end

    assign LoggedIn           = logged_q;
    assign LoggedInLED        = logged_q;
    assign PlayerID_from_pswd = pid_q;
    assign isGuest_from_PSWD  = guest_q;

endmodule

// File: tb/tb_authentication.sv
// Directed self-checking bench for the authentication login block.
// Define AUTH_GUEST_EN on both bench and RTL to exercise guest login.
module tb_authentication;

    logic       clk;
    logic       rst;
    logic [3:0] UserDigit;
    logic       UserLoad;
    logic       logout_from_gamectrl;
    logic       LoggedIn;
    logic [2:0] PlayerID_from_pswd;
    logic       isGuest_from_PSWD;
    logic       LoggedInLED;

    int passed = 0;
    int total  = 0;

    authentication dut (
        .clk                  (clk),
        .rst                  (rst),
        .UserDigit            (UserDigit),
        .UserLoad             (UserLoad),
        .logout_from_gamectrl (logout_from_gamectrl),
        .LoggedIn             (LoggedIn),
        .PlayerID_from_pswd   (PlayerID_from_pswd),
        .isGuest_from_PSWD    (isGuest_from_PSWD),
        .LoggedInLED          (LoggedInLED)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One digit: UserLoad high for 'hold' cycles; returns at the negedge where it drops.
    task automatic send(input logic [3:0] d, input int hold);
        @(negedge clk);
        UserDigit = d;
        UserLoad  = 1'b1;
        repeat (hold) @(negedge clk);
        UserLoad  = 1'b0;
    endtask

    task automatic send_id(input logic [15:0] id);
        for (int i = 0; i < 4; i++) send(id[12-4*i +: 4], 1);
    endtask

    task automatic send_pw(input logic [23:0] pw);
        for (int i = 0; i < 6; i++) send(pw[20-4*i +: 4], 1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_outputs(input string tag, input logic li, input logic [2:0] pid, input logic g);
        chk({tag, "_loggedin"}, {3'b0, LoggedIn}, {3'b0, li});
        chk({tag, "_led"}, {3'b0, LoggedInLED}, {3'b0, li});
        chk({tag, "_pid"}, {1'b0, PlayerID_from_pswd}, {1'b0, pid});
        chk({tag, "_guest"}, {3'b0, isGuest_from_PSWD}, {3'b0, g});
    endtask

    task automatic do_logout();
        @(negedge clk);
        logout_from_gamectrl = 1'b1;
        @(negedge clk);
        logout_from_gamectrl = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        UserDigit = 4'h0;
        UserLoad = 1'b0;
        logout_from_gamectrl = 1'b0;
        idle(2);
        chk_outputs("reset", 1'b0, 3'd0, 1'b0);
        rst = 1'b0;

        // Reset pulse mid-ID entry must restart the digit count
        send(4'h5, 1);
        send(4'h9, 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_outputs("midreset", 1'b0, 3'd0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        send_id(16'h5973);
        idle(70);
        send_pw(24'hA04A54);
        chk("p1_latency", {3'b0, LoggedIn}, 4'h0);
        @(negedge clk);
        chk_outputs("p1_login", 1'b1, 3'd1, 1'b0);

        // Logout with a simultaneous UserLoad edge; that digit must be dropped
        @(negedge clk);
        UserDigit = 4'h6;
        UserLoad = 1'b1;
        logout_from_gamectrl = 1'b1;
        @(negedge clk);
        logout_from_gamectrl = 1'b0;
        chk("logout_latency", {3'b0, LoggedIn}, 4'h1);
        UserLoad = 1'b0;
        @(negedge clk);
        chk_outputs("logout", 1'b0, 3'd0, 1'b0);

        send_id(16'h6197);
        idle(10);
        send_pw(24'h8957D1);
        chk("p2_latency", {3'b0, LoggedIn}, 4'h0);
        @(negedge clk);
        chk_outputs("p2_login", 1'b1, 3'd2, 1'b0);
        do_logout();
        chk_outputs("p2_logout", 1'b0, 3'd0, 1'b0);

        // Wrong last password digit
        send_id(16'h5973);
        idle(10);
        send_pw(24'hA04A55);
        idle(3);
        chk_outputs("badpw", 1'b0, 3'd0, 1'b0);

        // Next entry accepted; a logout pulse mid-entry is ignored
        send(4'h6, 1);
        @(negedge clk);
        logout_from_gamectrl = 1'b1;
        @(negedge clk);
        logout_from_gamectrl = 1'b0;
        send(4'h1, 1);
        send(4'h9, 1);
        send(4'h7, 1);
        idle(10);
        send_pw(24'h8957D1);
        @(negedge clk);
        chk_outputs("after_badpw", 1'b1, 3'd2, 1'b0);
        do_logout();

        // Unknown ID returns to ID entry
        send_id(16'h1234);
        idle(10);
        chk_outputs("unknown", 1'b0, 3'd0, 1'b0);

        // UserLoad held 5 cycles is a single digit
        send(4'h5, 5);
        send(4'h9, 1);
        send(4'h7, 1);
        send(4'h3, 1);
        idle(10);
        send_pw(24'hA04A54);
        @(negedge clk);
        chk_outputs("held_load", 1'b1, 3'd1, 1'b0);
        do_logout();

        // ID 0000: guest login if enabled, otherwise unknown
        send_id(16'h0000);
        idle(9);
`ifdef AUTH_GUEST_EN
        chk_outputs("guest", 1'b1, 3'd0, 1'b1);
        do_logout();
        chk_outputs("guest_logout", 1'b0, 3'd0, 1'b0);
`else
        chk_outputs("zero_id", 1'b0, 3'd0, 1'b0);
`endif
        send_id(16'h6197);
        idle(10);
        send_pw(24'h8957D1);
        @(negedge clk);
        chk_outputs("final_login", 1'b1, 3'd2, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
